// File: rtl/qif_pkg.sv
// Shared constants and helpers for the QIF neuron and its synapse front end.
package qif_pkg;

    localparam int DATA_W = 8;
    localparam int ACC_W = 11;
    localparam logic [7:0] WEIGHT_INIT_DEF = 8'd32;

    // Saturating 8-bit add, also used by the neuron core.
    function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        logic [DATA_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s[DATA_W]) begin
            return {DATA_W{1'b1}};
        end else begin
            return s[DATA_W-1:0];
        end
    endfunction

    function automatic logic [DATA_W-1:0] clip_acc(input logic [ACC_W-1:0] v);
        if (v > 11'd255) begin
            return 8'd255;
        end else begin
            return v[DATA_W-1:0];
        end
    endfunction

endpackage

// File: rtl/qif_prescaler.sv
// Decay prescaler: counts enabled cycles and pulses tick once per DECAY_DIV.
module qif_prescaler #(
    parameter logic [23:0] DECAY_DIV = 24'd1000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    logic [23:0] cnt_q;
    logic [23:0] cnt_d;

    // Next count: wrap on tick, advance while enabled, otherwise hold.
    always_comb begin
        tick = en && (cnt_q == (DECAY_DIV - 24'd1));
        if (tick) begin
            cnt_d = 24'd0;
        end else if (en) begin
            cnt_d = cnt_q + 24'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 24'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/qif_synapse.sv
// Synaptic current generator: spike edges add per-input weights to an
// exponentially decaying, saturating 8-bit current feeding the QIF neuron.
module qif_synapse
    import qif_pkg::*;
#(
    parameter int          N_IN        = 4,
    parameter int          TAU_SHIFT   = 3,
    parameter logic [23:0] DECAY_DIV   = 24'd1000,
    parameter logic [7:0]  WEIGHT_INIT = WEIGHT_INIT_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [N_IN-1:0]          spike_in,
    input  logic                     w_we,
    input  logic [$clog2(N_IN)-1:0]  w_addr,
    input  logic [7:0]               w_data,
    output logic [7:0]               I_syn,
    output logic                     tick,
    output logic                     sat
);

    localparam int AW = $clog2(N_IN);

    logic [N_IN-1:0]  s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [N_IN-1:0]  spk_edge;
    logic [7:0]       w_q [N_IN];
    logic [7:0]       w_d [N_IN];
    logic [7:0]       i_syn_q, i_syn_d;
    logic [ACC_W-1:0] shifted, d_term, a_term, next_val;

    qif_prescaler #(.DECAY_DIV(DECAY_DIV)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .tick (tick)
    );

    // Synchronizer chain; history flop runs even with en low so gated edges are lost.
    always_comb begin
        s1_d     = spike_in;
        s2_d     = s1_q;
        s3_d     = s2_q;
        spk_edge = s2_q & ~s3_q;
    end

    // Weight file write; out-of-range addresses match no entry.
    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            if (w_we && (w_addr == AW'(i))) begin
                w_d[i] = w_data;
            end else begin
                w_d[i] = w_q[i];
            end
        end
    end

    // Decay + accumulate; accumulation reads the pre-write weights.
    always_comb begin
        shifted = {3'b000, i_syn_q >> TAU_SHIFT};
        if (!tick) begin
            d_term = 11'd0;
        end else if ((shifted == 11'd0) && (i_syn_q != 8'd0)) begin
            d_term = 11'd1;
        end else begin
            d_term = shifted;
        end
        a_term = 11'd0;
        for (int i = 0; i < N_IN; i++) begin
            if (en && spk_edge[i]) begin
                a_term = a_term + {3'b000, w_q[i]};
            end else begin
                a_term = a_term;
            end
        end
        next_val = {3'b000, i_syn_q} - d_term + a_term;
        i_syn_d  = clip_acc(next_val);
        if (!rst && (next_val > 11'd255)) begin
            sat = 1'b1;
        end else begin
            sat = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= {N_IN{1'b0}};
            s2_q    <= {N_IN{1'b0}};
            s3_q    <= {N_IN{1'b0}};
            i_syn_q <= 8'd0;
            for (int i = 0; i < N_IN; i++) begin
                w_q[i] <= WEIGHT_INIT;
            end
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            s3_q    <= s3_d;
            i_syn_q <= i_syn_d;
            for (int i = 0; i < N_IN; i++) begin
                w_q[i] <= w_d[i];
            end
        end
    end

    assign I_syn = i_syn_q;

endmodule

// File: tb/tb_qif_synapse.sv
// Bench for qif_synapse: per-cycle reference model with a scoreboard queue,
// a table of weight/spike vectors and hand-derived multi-cycle sequences.
module tb_qif_synapse;

    localparam int DIV = 10;

    logic       clk = 1'b0;
    logic       rst, en, w_we;
    logic [3:0] spike_in;
    logic [1:0] w_addr;
    logic [7:0] w_data;
    logic [7:0] I_syn;
    logic       tick, sat;

    always #5 clk = ~clk;

    qif_synapse #(
        .N_IN(4), .TAU_SHIFT(3), .DECAY_DIV(24'd10), .WEIGHT_INIT(8'd32)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .spike_in(spike_in), .w_we(w_we),
        .w_addr(w_addr), .w_data(w_data), .I_syn(I_syn), .tick(tick), .sat(sat)
    );

    int n_vec = 0;
    int n_err = 0;
    int n_tick = 0;
    int n_sat = 0;

    logic [3:0] m_s1 = 4'd0, m_s2 = 4'd0, m_s3 = 4'd0;
    int         m_cnt = 0;
    int         m_I = 0;
    int         m_w [4] = '{32, 32, 32, 32};
    logic       m_tick_last = 1'b0;
    logic [7:0] exp_q [$];

    typedef struct {
        logic       we;
        logic [1:0] wa;
        logic [7:0] wd;
        logic [3:0] mask;
        int         exp_i;
        int         exp_sat;
    } vec_t;

    vec_t tbl [8];
    int   dec_list [21] = '{28, 25, 22, 20, 18, 16, 14, 13, 12, 11, 10,
                            9, 8, 7, 6, 5, 4, 3, 2, 1, 0};

    task automatic chk(input string nm, input int act, input int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
        end
    endtask

    // One clock: check combinational pulses, advance the model, score I_syn.
    task automatic step();
        int dd, aa, nxt;
        logic [3:0] ed;
        logic mt;
        #3;
        ed = m_s2 & ~m_s3;
        mt = en && (m_cnt == DIV - 1);
        dd = 0;
        if (mt) begin
            dd = m_I >> 3;
            if (dd == 0 && m_I > 0) dd = 1;
        end
        aa = 0;
        if (en) for (int i = 0; i < 4; i++) if (ed[i]) aa += m_w[i];
        nxt = m_I - dd + aa;
        if (!rst) begin
            chk("tick", int'(tick), int'(mt));
            chk("sat", int'(sat), (nxt > 255) ? 1 : 0);
        end
        if (tick) n_tick++;
        if (sat) n_sat++;
        m_tick_last = mt;
        if (rst) begin
            m_s1 = 4'd0; m_s2 = 4'd0; m_s3 = 4'd0;
            m_cnt = 0; m_I = 0;
            for (int i = 0; i < 4; i++) m_w[i] = 32;
        end else begin
            m_I = (nxt > 255) ? 255 : nxt;
            if (w_we) m_w[w_addr] = int'(w_data);
            m_s3 = m_s2; m_s2 = m_s1; m_s1 = spike_in;
            if (mt) m_cnt = 0;
            else if (en) m_cnt = m_cnt + 1;
        end
        exp_q.push_back(8'(m_I));
        @(posedge clk);
        #1;
        chk("I_syn", int'(I_syn), int'(exp_q.pop_front()));
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; spike_in = 4'd0; w_we = 1'b0;
        w_addr = 2'd0; w_data = 8'd0;
        step();
        rst = 1'b0;
    endtask

    task automatic pulse(input logic [3:0] m);
        spike_in = m;
        step();
        spike_in = 4'd0;
        step();
        step();
    endtask

    initial begin
        int k;
        tbl[0] = '{1'b0, 2'd0, 8'd0,   4'b0001, 32,  0};
        tbl[1] = '{1'b1, 2'd1, 8'd200, 4'b0110, 232, 0};
        tbl[2] = '{1'b1, 2'd3, 8'd255, 4'b1001, 255, 1};
        tbl[3] = '{1'b1, 2'd2, 8'd0,   4'b1111, 96,  0};
        tbl[4] = '{1'b0, 2'd0, 8'd0,   4'b1111, 128, 0};
        tbl[5] = '{1'b1, 2'd0, 8'd224, 4'b0011, 255, 1};
        tbl[6] = '{1'b1, 2'd0, 8'd223, 4'b0011, 255, 0};
        tbl[7] = '{1'b0, 2'd0, 8'd0,   4'b0000, 0,   0};

        do_reset();
        do_reset();
        chk("reset_I", int'(I_syn), 0);
        chk("reset_tick", int'(tick), 0);

        // Idle decay: three ticks, nothing else.
        en = 1'b1; n_tick = 0; n_sat = 0;
        run(3 * DIV);
        chk("idle_ticks", n_tick, 3);
        chk("idle_sat", n_sat, 0);
        chk("idle_I", int'(I_syn), 0);

        // Table: one write, one simultaneous pulse, result before first tick.
        for (int v = 0; v < 8; v++) begin
            do_reset();
            w_we = tbl[v].we; w_addr = tbl[v].wa; w_data = tbl[v].wd;
            step();
            w_we = 1'b0; en = 1'b1; n_sat = 0;
            pulse(tbl[v].mask);
            chk("tbl_I", int'(I_syn), tbl[v].exp_i);
            chk("tbl_sat", n_sat, tbl[v].exp_sat);
        end

        // Single pulse then full decay to zero.
        do_reset();
        en = 1'b1;
        pulse(4'b0001);
        chk("decay_start", int'(I_syn), 32);
        k = 0;
        repeat (25 * DIV) begin
            step();
            if (m_tick_last) begin
                chk("decay_step", int'(I_syn), (k < 21) ? dec_list[k] : 0);
                k++;
            end
        end

        // Saturation with two large weights, then hold without tick.
        do_reset();
        w_we = 1'b1; w_addr = 2'd1; w_data = 8'd200; step();
        w_addr = 2'd2; w_data = 8'd100; step();
        w_we = 1'b0; en = 1'b1; n_sat = 0;
        pulse(4'b0110);
        chk("sat_I", int'(I_syn), 255);
        chk("sat_count", n_sat, 1);
        run(5);
        chk("sat_hold", int'(I_syn), 255);

        // Held spike counts once; re-arm after dropping low.
        do_reset();
        en = 1'b1; spike_in = 4'b1000;
        run(50);
        spike_in = 4'd0;
        run(3);
        chk("hold_once", int'(I_syn), 18);
        pulse(4'b1000);
        chk("hold_twice", int'(I_syn), 50);

        // en low: spike dropped, counter frozen at 6.
        en = 1'b0;
        spike_in = 4'b0001; step();
        spike_in = 4'd0; run(4);
        chk("en_hold", int'(I_syn), 50);
        en = 1'b1;
        run(3);
        chk("en_nospike", int'(I_syn), 50);
        step();
        chk("en_resume", int'(I_syn), 44);

        // Edge coincides with tick at I_syn = 5, w[0] = 10.
        do_reset();
        w_we = 1'b1; w_addr = 2'd0; w_data = 8'd5; step();
        w_we = 1'b0; en = 1'b1;
        pulse(4'b0001);
        chk("coinc_five", int'(I_syn), 5);
        w_we = 1'b1; w_data = 8'd10; step();
        w_we = 1'b0;
        run(3);
        spike_in = 4'b0001; step();
        spike_in = 4'd0; step();
        chk("coinc_pre", int'(I_syn), 5);
        step();
        chk("coinc_14", int'(I_syn), 14);
        rst = 1'b1; step(); rst = 1'b0;
        chk("coinc_rst", int'(I_syn), 0);
        pulse(4'b0001);
        chk("rst_weight", int'(I_syn), 32);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/qif_synapse.md
# qif_synapse

Synaptic current generator that sits directly upstream of the QIF neuron and drives its 8-bit `I_syn` input. It turns up to four presynaptic spike lines into one exponentially decaying synaptic current. Each rising spike edge adds a programmable per-input weight. The current decays by a fixed shift every prescaled tick and saturates at full scale.

## Interface
Parameters:
- `N_IN`, 4: number of presynaptic spike inputs (2 <= N_IN <= 8).
- `TAU_SHIFT`, 3: decay shift; decay step = I_syn >> TAU_SHIFT.
- `DECAY_DIV`, 24'd1000: clock cycles per decay tick (>= 2).
- `WEIGHT_INIT`, 8'd32: reset value of every weight.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `en` in 1: enable; low freezes decay and spike accumulation.
- `spike_in` in N_IN: asynchronous presynaptic spike levels.
- `w_we` in 1: weight write strobe.
- `w_addr` in $clog2(N_IN): weight index.
- `w_data` in 8: weight value, unsigned.
- `I_syn` out 8: synaptic current to the neuron, unsigned, registered.
- `tick` out 1: one-cycle pulse in the cycle the decay is applied.
- `sat` out 1: one-cycle pulse when the update in that cycle clipped at 255.

## Operation
- Input path: each `spike_in` bit passes through a 2-flop synchronizer (`s1`, `s2`) and a history flop `s3`. The edge vector is `edge = s2 & ~s3`. The history flop updates every cycle, including when `en` is low. Edges that occur while `en` is low are therefore dropped and are not deferred.
- Weights: N_IN x 8-bit register file. When `w_we` is high, `w[w_addr]` is written. `w_addr >= N_IN` is ignored. Writes are accepted regardless of `en`.
- Prescaler: counter runs 0..DECAY_DIV-1 while `en` is high and holds while `en` is low. `tick` = en && (cnt == DECAY_DIV-1). On `tick` the counter wraps to 0.
- Decay term `d`:
  - When `tick` is low, d = 0.
  - When `tick` is high, d = I_syn >> TAU_SHIFT.
  - If that shift result is 0 and I_syn > 0, then d = 1. This guarantees the current decays to 0.
- Accumulate term `a`: the sum of `w[i]` over every set `edge[i]`, computed 11 bits wide. When `en` is low, a = 0.
- Update, every cycle: next = I_syn - d + a in 11-bit unsigned.
  - If next > 255, I_syn <= 255 and `sat` = 1.
  - Otherwise I_syn <= next.
  - Decay and accumulation apply together in the same cycle. Decay uses the pre-update I_syn.
- Write/spike collision: a weight write in the same cycle as an edge on that input uses the old weight. The new weight takes effect from the next cycle.
- Reset values: I_syn = 0, tick = 0, sat = 0, cnt = 0, s1/s2/s3 = 0, all weights = WEIGHT_INIT.

## Timing
- Spike latency: `spike_in[i]` is first sampled high at edge N. `edge[i]` is high in cycle N+1 to N+2. I_syn reflects the added weight after edge N+2.
- A spike held high for many cycles produces exactly one edge. It must be low for at least 2 sampled cycles before it can be counted again.
- `tick` period is DECAY_DIV cycles of `en` high. `tick` and `sat` are combinational from registered state. Both must be stable before the next rising edge.
- `rst` takes priority over `en`, `w_we` and all spikes. When `rst` is asserted mid-accumulation, I_syn = 0 after that edge and any in-flight synchronizer edges are discarded.
- I_syn never wraps. It is clamped at 255 and, because of the minimum d of 1, never underflows below 0.

## Structure
- Shared package `qif_pkg` holds:
  - the data width constant (8) and the accumulator width constant (11);
  - the default `WEIGHT_INIT`;
  - a saturating-add function reused by the neuron.
- One sub-module, `qif_prescaler`, contains the DECAY_DIV counter with its enable and tick output. Synchronizers, weight file and accumulator stay in the top level.

## Test plan
- Reset, then en = 1 with no spikes for 3*DECAY_DIV cycles -> I_syn = 0, tick pulses every DECAY_DIV cycles, sat never asserts, weights read back as 32 via their effect.
- Single pulse on spike_in[0] with default weight -> I_syn = 32 two edges after first sampling. At the next tick I_syn = 28 (32-4), then 25, 22, ...; it reaches 0 and stays there.
- Write w[1] = 200, w[2] = 100, then pulse both inputs simultaneously -> I_syn = 255 and `sat` pulses once. With no tick, I_syn holds at 255.
- Hold spike_in[3] high for 50 cycles -> exactly one accumulation of w[3]. Drop it low for 2+ cycles and raise again -> second accumulation.
- Drive en = 0 and pulse spike_in[0] -> no change to I_syn and cnt frozen. After raising en, cnt resumes from its held value and the dropped spike is not added.
- Spike edge coincides with tick while I_syn = 5 and w[0] = 10 -> I_syn = 5-1+10 = 14. Then assert rst for one cycle -> I_syn = 0 and weights back to 32.
